// File: rtl/irrigation_display_decoder.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_display_decoder
// Description : Filters the 2-bit irrigation code for stability, decodes it to
//               a mode word and drives a 4-digit multiplexed 7-segment display
//               (active-low segments and digit selects). Fault word blinks.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_display_decoder #(
  parameter int SCAN_DIV      = 1000,
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_DIV     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] irrigation_encoded,
  input  logic       display_enable,
  output logic [6:0] segments,
  output logic [3:0] digit_select,
  output logic [1:0] current_code,
  output logic       code_valid,
  output logic       code_changed
);

  localparam int SCAN_W   = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
  localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int BLINK_W  = (BLINK_DIV > 1)     ? $clog2(BLINK_DIV)     : 1;

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

  localparam logic [1:0] CODE_DRIP   = 2'b00;
  localparam logic [1:0] CODE_SPRINK = 2'b01;
  localparam logic [1:0] CODE_FAULT  = 2'b10;
  localparam logic [1:0] CODE_INVAL  = 2'b11;

  localparam logic [6:0] GLYPH_G     = 7'h42;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_T     = 7'h07;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_R     = 7'h2F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  logic [SCAN_W-1:0]   prescaler;
  logic [1:0]          digit_index;
  logic [BLINK_W-1:0]  frame_count;
  logic                blink_phase;
  logic [1:0]          candidate;
  logic [STABLE_W-1:0] stable_count;

  logic scan_wrap;
  logic frame_end;
  logic commit;
  logic blank;

  // Glyph lookup: word for a code, one character per digit slot.
  function automatic logic [6:0] glyph_for(input logic [1:0] code, input logic [1:0] idx);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (code)
      CODE_DRIP: begin
        case (idx)
          2'd0:    g = GLYPH_G;
          2'd1:    g = GLYPH_O;
          2'd2:    g = GLYPH_T;
          default: g = GLYPH_BLANK;
        endcase
      end
      CODE_SPRINK: begin
        case (idx)
          2'd0:    g = GLYPH_A;
          2'd1:    g = GLYPH_S;
          2'd2:    g = GLYPH_P;
          default: g = GLYPH_BLANK;
        endcase
      end
      CODE_FAULT: begin
        case (idx)
          2'd0:    g = GLYPH_E;
          2'd1:    g = GLYPH_R;
          2'd2:    g = GLYPH_R;
          default: g = GLYPH_BLANK;
        endcase
      end
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  // Scan timing strobes, commit decision and display blanking condition.
  always_comb begin
    scan_wrap = (prescaler == SCAN_LAST);
    frame_end = scan_wrap && (digit_index == 2'd3);
    commit    = (irrigation_encoded == candidate) &&
                (stable_count == STABLE_LAST) &&
                (candidate != current_code);
    blank     = !display_enable || ((current_code == CODE_FAULT) && blink_phase);
  end

  // Stability filter: a code must be seen unchanged for STABLE_CYCLES edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      candidate    <= CODE_INVAL;
      stable_count <= '0;
      current_code <= CODE_INVAL;
      code_valid   <= 1'b0;
      code_changed <= 1'b0;
    end else begin
      code_changed <= 1'b0;
      if (irrigation_encoded != candidate) begin
        candidate    <= irrigation_encoded;
        stable_count <= '0;
      end else if (stable_count < STABLE_LAST) begin
        stable_count <= stable_count + 1'b1;
      end else if (commit) begin
        current_code <= candidate;
        code_valid   <= ~candidate[1];
        code_changed <= 1'b1;
      end
    end
  end

  // Digit scan: prescaler paces each digit slot, index walks 0..3.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler   <= '0;
      digit_index <= 2'd0;
    end else if (scan_wrap) begin
      prescaler   <= '0;
      digit_index <= digit_index + 2'd1;
    end else begin
      prescaler   <= prescaler + 1'b1;
    end
  end

  // Blink timing: counts frames; a fresh commit restarts in the visible phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (commit) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_count == BLINK_LAST) begin
        frame_count <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  // Registered display outputs, one cycle behind the index and code shown.
  always_ff @(posedge clock) begin
    if (reset) begin
      segments     <= GLYPH_BLANK;
      digit_select <= 4'b1111;
    end else if (blank) begin
      segments     <= GLYPH_BLANK;
      digit_select <= 4'b1111;
    end else begin
      segments     <= glyph_for(current_code, digit_index);
      digit_select <= ~(4'b0001 << digit_index);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irrigation_display_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_display_decoder
// Description : Directed, table-driven bench for irrigation_display_decoder
//               with SCAN_DIV=4, STABLE_CYCLES=4, BLINK_DIV=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irrigation_display_decoder;

  logic       clock;
  logic       reset;
  logic [1:0] irrigation_encoded;
  logic       display_enable;
  logic [6:0] segments;
  logic [3:0] digit_select;
  logic [1:0] current_code;
  logic       code_valid;
  logic       code_changed;

  int tests;
  int failed;

  typedef struct {
    logic [1:0] code;
    logic       en;
    int         cycles;
    logic [6:0] seg;
    logic [3:0] dsel;
    logic [1:0] cur;
    logic       valid;
    logic       changed;
  } vec_t;

  vec_t vecs[$];

  irrigation_display_decoder #(
    .SCAN_DIV      (4),
    .STABLE_CYCLES (4),
    .BLINK_DIV     (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .irrigation_encoded (irrigation_encoded),
    .display_enable     (display_enable),
    .segments           (segments),
    .digit_select       (digit_select),
    .current_code       (current_code),
    .code_valid         (code_valid),
    .code_changed       (code_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] code, input logic en, input int cycles,
                     input logic [6:0] seg, input logic [3:0] dsel, input logic [1:0] cur,
                     input logic valid, input logic changed);
    vec_t v;
    v.code = code; v.en = en; v.cycles = cycles; v.seg = seg; v.dsel = dsel;
    v.cur = cur; v.valid = valid; v.changed = changed;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [6:0] seg, input logic [3:0] dsel,
                         input logic [1:0] cur, input logic valid, input logic changed);
    chk({tag, " segments"},     32'(segments),     32'(seg));
    chk({tag, " digit_select"}, 32'(digit_select), 32'(dsel));
    chk({tag, " current_code"}, 32'(current_code), 32'(cur));
    chk({tag, " code_valid"},   32'(code_valid),   32'(valid));
    chk({tag, " code_changed"}, 32'(code_changed), 32'(changed));
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Edge numbers in comments count rising edges after reset release.
    // Invalid word, first frame: dashes on each digit, 4 cycles each.
    add(2'b11, 1, 1,  7'h3F, 4'b1110, 2'b11, 0, 0); // e1
    add(2'b11, 1, 4,  7'h3F, 4'b1101, 2'b11, 0, 0); // e5
    add(2'b11, 1, 4,  7'h3F, 4'b1011, 2'b11, 0, 0); // e9
    add(2'b11, 1, 4,  7'h3F, 4'b0111, 2'b11, 0, 0); // e13
    // Sprinkler held from e14, commits at e18.
    add(2'b01, 1, 1,  7'h3F, 4'b0111, 2'b11, 0, 0); // e14
    add(2'b01, 1, 3,  7'h3F, 4'b1110, 2'b11, 0, 0); // e17
    add(2'b01, 1, 1,  7'h3F, 4'b1110, 2'b01, 1, 1); // e18 commit, display lags
    add(2'b01, 1, 1,  7'h08, 4'b1110, 2'b01, 1, 0); // e19
    add(2'b01, 1, 4,  7'h12, 4'b1101, 2'b01, 1, 0); // e23
    add(2'b01, 1, 4,  7'h0C, 4'b1011, 2'b01, 1, 0); // e27
    add(2'b01, 1, 4,  7'h7F, 4'b0111, 2'b01, 1, 0); // e31
    // Display disabled for 10 cycles, scan keeps running.
    add(2'b01, 0, 1,  7'h7F, 4'b1111, 2'b01, 1, 0); // e32
    add(2'b01, 0, 9,  7'h7F, 4'b1111, 2'b01, 1, 0); // e41
    add(2'b01, 1, 1,  7'h0C, 4'b1011, 2'b01, 1, 0); // e42 free-running digit 2
    add(2'b01, 1, 6,  7'h7F, 4'b0111, 2'b01, 1, 0); // e48 blink toggles, no effect
    add(2'b01, 1, 1,  7'h08, 4'b1110, 2'b01, 1, 0); // e49 sprinkler does not blink
    // Dripper from e50, commits at e54.
    add(2'b00, 1, 4,  7'h12, 4'b1101, 2'b01, 1, 0); // e53
    add(2'b00, 1, 1,  7'h12, 4'b1101, 2'b00, 1, 1); // e54 commit
    add(2'b00, 1, 3,  7'h07, 4'b1011, 2'b00, 1, 0); // e57
    // Three-cycle sprinkler glitch: no commit, no pulse.
    add(2'b01, 1, 1,  7'h07, 4'b1011, 2'b00, 1, 0); // e58
    add(2'b01, 1, 1,  7'h07, 4'b1011, 2'b00, 1, 0); // e59
    add(2'b01, 1, 1,  7'h07, 4'b1011, 2'b00, 1, 0); // e60
    add(2'b00, 1, 1,  7'h7F, 4'b0111, 2'b00, 1, 0); // e61
    add(2'b00, 1, 6,  7'h42, 4'b1110, 2'b00, 1, 0); // e67
    add(2'b00, 1, 4,  7'h40, 4'b1101, 2'b00, 1, 0); // e71
    // Fault from e72, commits at e76 (same edge as a digit advance).
    add(2'b10, 1, 4,  7'h07, 4'b1011, 2'b00, 1, 0); // e75
    add(2'b10, 1, 1,  7'h07, 4'b1011, 2'b10, 0, 1); // e76 commit
    add(2'b10, 1, 1,  7'h7F, 4'b0111, 2'b10, 0, 0); // e77
    add(2'b10, 1, 4,  7'h06, 4'b1110, 2'b10, 0, 0); // e81
    add(2'b10, 1, 4,  7'h2F, 4'b1101, 2'b10, 0, 0); // e85
    add(2'b10, 1, 4,  7'h2F, 4'b1011, 2'b10, 0, 0); // e89
    // Blink phase set at e96: blanked until it clears at e128.
    add(2'b10, 1, 8,  7'h7F, 4'b1111, 2'b10, 0, 0); // e97
    add(2'b10, 1, 4,  7'h7F, 4'b1111, 2'b10, 0, 0); // e101
    add(2'b10, 1, 27, 7'h7F, 4'b1111, 2'b10, 0, 0); // e128
    add(2'b10, 1, 1,  7'h06, 4'b1110, 2'b10, 0, 0); // e129 visible again
    add(2'b10, 1, 4,  7'h2F, 4'b1101, 2'b10, 0, 0); // e133
    add(2'b10, 1, 30, 7'h7F, 4'b1111, 2'b10, 0, 0); // e163 blank phase again

    // Reset held three cycles.
    reset              = 1'b1;
    irrigation_encoded = 2'b11;
    display_enable     = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all("reset", 7'h7F, 4'b1111, 2'b11, 0, 0);
    reset = 1'b0;

    // Apply the vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      irrigation_encoded = vecs[i].code;
      display_enable     = vecs[i].en;
      repeat (vecs[i].cycles) @(posedge clock);
      @(negedge clock);
      chk_all($sformatf("step%0d", i), vecs[i].seg, vecs[i].dsel, vecs[i].cur,
              vecs[i].valid, vecs[i].changed);
    end

    // Reset mid-frame while the fault word is in its blank phase.
    reset              = 1'b1;
    irrigation_encoded = 2'b11;
    @(posedge clock);
    @(negedge clock);
    chk_all("midreset", 7'h7F, 4'b1111, 2'b11, 0, 0);
    chk("midreset blink_phase", 32'(dut.blink_phase), 32'd0);
    reset = 1'b0;

    // Scan restarts from digit 0 with the invalid word.
    @(posedge clock);
    @(negedge clock);
    chk_all("postreset d0", 7'h3F, 4'b1110, 2'b11, 0, 0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk_all("postreset d1", 7'h3F, 4'b1101, 2'b11, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
